// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared constants and types for the CORDIC sequencer:
//   - default fractional width, shift-value width and iteration count
//   - CORDIC gain compensation constant K (Q1.15)
//   - arctangent table atan(2^-k) in phase units (pi = 32768)
//   - FSM state type and the quadrant-fold threshold
// -----------------------------------------------------------------------------
package cordic_pkg;

   localparam int CORDIC_N_FRAC         = 15;
   localparam int CORDIC_BW_SHIFT_VALUE = 4;
   localparam int CORDIC_N_ITER         = 15;

   // 0.60725 in Q1.15; pre-scales x0 so the rotated vector ends at unit length.
   localparam logic signed [15:0] CORDIC_K = 16'sd19898;

   // Inputs beyond +/- pi/2 are folded by half a turn so the rotation
   // starts inside the CORDIC convergence range.
   localparam logic signed [15:0] FOLD_LIMIT = 16'sd16384;

   localparam int ATAN_LEN = 15;
   localparam logic signed [15:0] ATAN_TABLE [ATAN_LEN] = '{
      16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651,
      16'sd326,  16'sd163,  16'sd81,   16'sd41,   16'sd20,
      16'sd10,   16'sd5,    16'sd3,    16'sd1,    16'sd1
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// -----------------------------------------------------------------------------
// cordic_atan_rom
// Combinational lookup of the micro-rotation angle atan(2^-k).
// Ports:
//   k      in   shift value / iteration index
//   angle  out  atan(2^-k) in phase units (pi = 32768); 0 beyond the table
// -----------------------------------------------------------------------------
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int BW_SHIFT_VALUE = CORDIC_BW_SHIFT_VALUE
) (
   input  logic [BW_SHIFT_VALUE-1:0] k,
   output logic signed [15:0]        angle
);

   // One masked copy per table entry; exactly one is non-zero for a
   // valid index, so OR-ing them selects the entry.
   logic [15:0] masked [ATAN_LEN];

   genvar gi;
   generate
      for (gi = 0; gi < ATAN_LEN; gi++) begin : g_entry
         assign masked[gi] = (k == BW_SHIFT_VALUE'(gi)) ? ATAN_TABLE[gi] : 16'd0;
      end
   endgenerate

   always_comb begin
      logic [15:0] acc;
      acc = 16'd0;
      for (int i = 0; i < ATAN_LEN; i++) begin
         acc = acc | masked[i];
      end
      angle = signed'(acc);
   end

endmodule

// File: rtl/cordic_sequencer.sv
// -----------------------------------------------------------------------------
// cordic_sequencer
// Iterative CORDIC controller: accepts one phase, folds it into +/- pi/2,
// drives an external registered slice stage for N_ITER micro-rotations and
// returns cos/sin in Q1.15.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   angle_i, valid_i, ready_o     phase input handshake (-32768 = -pi)
//   slice_x/y/z_o                 operands to the slice stage
//   slice_angle_o, slice_shift_o  atan(2^-k) and k for the slice stage
//   slice_x/y/z_i                 slice results, one cycle after operands
//   cos_o, sin_o, valid_o         result (held) and one-cycle strobe
// -----------------------------------------------------------------------------
module cordic_sequencer
   import cordic_pkg::*;
#(
   parameter int N_FRAC         = CORDIC_N_FRAC,
   parameter int BW_SHIFT_VALUE = CORDIC_BW_SHIFT_VALUE,
   parameter int N_ITER         = CORDIC_N_ITER
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic signed [15:0]        angle_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   output logic signed [N_FRAC:0]    slice_x_o,
   output logic signed [N_FRAC:0]    slice_y_o,
   output logic signed [15:0]        slice_z_o,
   output logic signed [15:0]        slice_angle_o,
   output logic [BW_SHIFT_VALUE-1:0] slice_shift_o,
   input  logic signed [N_FRAC:0]    slice_x_i,
   input  logic signed [N_FRAC:0]    slice_y_i,
   input  logic signed [15:0]        slice_z_i,
   output logic signed [N_FRAC:0]    cos_o,
   output logic signed [N_FRAC:0]    sin_o,
   output logic                      valid_o
);

   localparam int DW = N_FRAC + 1;
   localparam logic [BW_SHIFT_VALUE-1:0] K_LAST = BW_SHIFT_VALUE'(N_ITER - 1);
   localparam logic signed [DW-1:0] DATA_MIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] DATA_MAX = {1'b0, {(DW-1){1'b1}}};

   state_t                    state_reg, state_next;
   logic [BW_SHIFT_VALUE-1:0] k_reg, k_next;
   logic signed [15:0]        z0_reg;
   logic                      neg_reg;
   logic signed [DW-1:0]      cos_reg, sin_reg;
   logic                      valid_reg;

   logic                      fold;
   logic                      accept;
   logic signed [15:0]        rom_angle;

   // Two's-complement negation with the single overflow case clipped.
   function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
      if (v == DATA_MIN) begin
         return DATA_MAX;
      end
      return -v;
   endfunction

   // Flipping the MSB adds pi; the final result is negated to compensate.
   assign fold = (angle_i > FOLD_LIMIT) || (angle_i < -FOLD_LIMIT);

   cordic_atan_rom #(
      .BW_SHIFT_VALUE(BW_SHIFT_VALUE)
   ) u_atan_rom (
      .k     (k_reg),
      .angle (rom_angle)
   );

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      ready_o    = 1'b0;
      accept     = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               accept     = 1'b1;
               k_next     = '0;
               state_next = ST_ROTATE;
            end
         end
         ST_ROTATE: begin
            if (k_reg == K_LAST) begin
               k_next     = '0;
               state_next = ST_DONE;
            end else begin
               k_next = k_reg + BW_SHIFT_VALUE'(1);
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            k_next     = '0;
         end
      endcase
   end

   // State, operand latch and result registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         k_reg     <= '0;
         z0_reg    <= '0;
         neg_reg   <= 1'b0;
         cos_reg   <= '0;
         sin_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         valid_reg <= (state_reg == ST_DONE);
         if (accept) begin
            z0_reg  <= fold ? (angle_i ^ 16'sh8000) : angle_i;
            neg_reg <= fold;
         end
         if (state_reg == ST_DONE) begin
            cos_reg <= neg_reg ? neg_sat(slice_x_i) : slice_x_i;
            sin_reg <= neg_reg ? neg_sat(slice_y_i) : slice_y_i;
         end
      end
   end

   // Operand mux: seed values on the first micro-rotation, then feed the
   // slice stage's registered results straight back.
   always_comb begin
      slice_x_o     = '0;
      slice_y_o     = '0;
      slice_z_o     = '0;
      slice_angle_o = '0;
      slice_shift_o = '0;
      if (state_reg == ST_ROTATE) begin
         slice_shift_o = k_reg;
         slice_angle_o = rom_angle;
         if (k_reg == '0) begin
            slice_x_o = CORDIC_K;
            slice_y_o = '0;
            slice_z_o = z0_reg;
         end else begin
            slice_x_o = slice_x_i;
            slice_y_o = slice_y_i;
            slice_z_o = slice_z_i;
         end
      end
   end

   assign cos_o   = cos_reg;
   assign sin_o   = sin_reg;
   assign valid_o = valid_reg;

endmodule
